// File: rtl/read_data_assembler.sv
// Collects BEATS backend read words from a show-ahead FIFO into one wide frontend burst,
// then holds it with a registered valid until the frontend accepts it.
`ifndef BACKEND_WORD_SIZE
`define BACKEND_WORD_SIZE 32
`endif

module read_data_assembler #(
    parameter int unsigned DATA_WIDTH = `BACKEND_WORD_SIZE,
    parameter int unsigned BEATS      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_WIDTH-1:0]         i_fifo_data,
    input  logic                          i_fifo_empty,
    output logic                          o_fifo_rd_en,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [BEATS*DATA_WIDTH-1:0]   o_rd_data,
    output logic                          o_busy,
    output logic [15:0]                   o_burst_cnt
);

    localparam int unsigned CntW = $clog2(BEATS);

    typedef enum logic {StCollect, StDeliver} state_e;

    state_e                             state_q, state_d;
    logic [CntW-1:0]                    beat_cnt_q, beat_cnt_d;
    logic [15:0]                        burst_cnt_q, burst_cnt_d;
    logic [BEATS-1:0][DATA_WIDTH-1:0]   beats_q;
    logic                               pop;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        pop         = 1'b0;
        unique case (state_q)
            StCollect: begin
                // Gating with reset keeps the FIFO untouched while the block is held in reset.
                pop = !i_fifo_empty && i_rst_n;
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                    if (beat_cnt_q == CntW'(BEATS - 1)) begin
                        state_d = StDeliver;
                    end
                end
            end
            StDeliver: begin
                if (i_rd_ready) begin
                    state_d     = StCollect;
                    burst_cnt_d = burst_cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StCollect;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beats_q <= '0;
        end else if (pop) begin
            beats_q[beat_cnt_q] <= i_fifo_data;
        end
    end

    assign o_fifo_rd_en = pop;
    assign o_rd_valid   = (state_q == StDeliver);
    assign o_rd_data    = beats_q;
    assign o_busy       = (state_q == StDeliver) || (beat_cnt_q != '0);
    assign o_burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_read_data_assembler.sv
// Directed bench for read_data_assembler: a queue models the show-ahead FIFO, inputs change
// just after the rising edge and outputs are sampled on the falling edge.
module tb_read_data_assembler;

    localparam int DW = 32;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   fifo_data;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic            rd_valid;
    logic            rd_ready;
    logic [NB*DW-1:0] rd_data;
    logic            busy;
    logic [15:0]     burst_cnt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int pops   = 0;

    logic [DW-1:0]    fifo_q[$];
    logic [NB*DW-1:0] hs_data[$];
    int               hs_cycle[$];

    logic             prev_hold = 1'b0;
    logic [NB*DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    read_data_assembler #(
        .DATA_WIDTH(DW),
        .BEATS     (NB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_fifo_data (fifo_data),
        .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(fifo_rd_en),
        .o_rd_valid  (rd_valid),
        .i_rd_ready  (rd_ready),
        .o_rd_data   (rd_data),
        .o_busy      (busy),
        .o_burst_cnt (burst_cnt)
    );

    // Protocol monitor: no pop from an empty FIFO or in DELIVER; data frozen under back-pressure.
    always @(negedge clk) begin
        if (fifo_empty === 1'b1) begin
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL pop_while_empty: rd_en=%b required 0 at cycle %0d", fifo_rd_en, cycle);
            end
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL pop_in_deliver: rd_en=%b required 0 at cycle %0d", fifo_rd_en, cycle);
            end
        end
        if (prev_hold && rd_valid === 1'b1) begin
            checks++;
            if (rd_data !== prev_data) begin
                errors++;
                $display("FAIL data_stable: got %h required %h", rd_data, prev_data);
            end
        end
        prev_hold = (rd_valid === 1'b1) && (rd_ready === 1'b0) && (rst_n === 1'b1);
        prev_data = rd_data;
    end

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic tick();
        logic popped;
        @(negedge clk);
        popped = fifo_rd_en;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            hs_data.push_back(rd_data);
            hs_cycle.push_back(cycle);
        end
        @(posedge clk);
        #1;
        if (popped === 1'b1) begin
            pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        cycle++;
        drive_fifo();
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        drive_fifo();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b required 0", rd_valid);
        end
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en);
        end
        checks++;
        if (burst_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_burst_cnt: got %0d required 0", burst_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h required 0", rd_data);
        end
    endtask

    task automatic test_basic();
        int p0;
        rd_ready = 1'b1;
        fifo_q.push_back(32'h11);
        fifo_q.push_back(32'h22);
        fifo_q.push_back(32'h33);
        fifo_q.push_back(32'h44);
        drive_fifo();
        p0 = pops;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pops - p0 != 4) begin
            errors++; $display("FAIL basic_pops: got %0d required 4", pops - p0);
        end
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b required 1", rd_valid);
        end
        checks++;
        if (rd_data !== 128'h00000044_00000033_00000022_00000011) begin
            errors++;
            $display("FAIL basic_data: got %h required %h", rd_data,
                     128'h00000044_00000033_00000022_00000011);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b required 1", busy);
        end
        tick();
        checks++;
        if (burst_cnt !== 16'd1) begin
            errors++; $display("FAIL basic_burst_cnt: got %0d required 1", burst_cnt);
        end
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_hs: valid=%b busy=%b required 0 0", rd_valid, busy);
        end
    endtask

    task automatic test_back_pressure();
        int p0;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
        drive_fifo();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hB0 + 32'(i));
        drive_fifo();
        p0 = pops;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pops != p0) begin
            errors++; $display("FAIL bp_no_pop: got %0d pops required 0", pops - p0);
        end
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++; $display("FAIL bp_valid: got %b required 1", rd_valid);
        end
        checks++;
        if (rd_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++; $display("FAIL bp_data: got %h required A3..A0", rd_data);
        end
        checks++;
        if (burst_cnt !== 16'd1) begin
            errors++; $display("FAIL bp_cnt_hold: got %0d required 1", burst_cnt);
        end
        rd_ready = 1'b1;
        tick();
        checks++;
        if (pops != p0) begin
            errors++; $display("FAIL bp_hs_no_pop: got %0d pops required 0", pops - p0);
        end
        checks++;
        if (burst_cnt !== 16'd2 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: cnt=%0d valid=%b required 2 0", burst_cnt, rd_valid);
        end
        tick();
        checks++;
        if (pops != p0 + 1) begin
            errors++; $display("FAIL bp_resume: got %0d pops required 1", pops - p0);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 128'h000000B3_000000B2_000000B1_000000B0) begin
            errors++; $display("FAIL bp_second: valid=%b data=%h required 1 B3..B0", rd_valid, rd_data);
        end
        tick();
        checks++;
        if (burst_cnt !== 16'd3) begin
            errors++; $display("FAIL bp_cnt_final: got %0d required 3", burst_cnt);
        end
    endtask

    task automatic test_gapped();
        rd_ready = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL gap_idle_busy: got %b required 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(32'hC0DE0001 + 32'(i));
            drive_fifo();
            tick();
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checks++;
                    if (busy !== 1'b1 || rd_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_busy: busy=%b valid=%b required 1 0", busy, rd_valid);
                    end
                    checks++;
                    if (dut.beat_cnt_q !== 2'(i + 1)) begin
                        errors++;
                        $display("FAIL gap_beat_cnt: got %0d required %0d", dut.beat_cnt_q, i + 1);
                    end
                end
            end
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001) begin
            errors++; $display("FAIL gap_data: valid=%b data=%h", rd_valid, rd_data);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || burst_cnt !== 16'd4) begin
            errors++; $display("FAIL gap_done: busy=%b cnt=%0d required 0 4", busy, burst_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int p0;
        rd_ready = 1'b1;
        fifo_q.push_back(32'hD0000001);
        fifo_q.push_back(32'hD0000002);
        drive_fifo();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b required 1", busy);
        end
        fifo_q.push_back(32'hEEEEEEEE);
        drive_fifo();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || burst_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_async_clear: valid=%b busy=%b cnt=%0d required 0 0 0",
                     rd_valid, busy, burst_cnt);
        end
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL mid_rd_en_in_reset: got %b required 0", fifo_rd_en);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL mid_slots_clear: got %h required 0", rd_data);
        end
        p0 = pops;
        tick();
        tick();
        checks++;
        if (pops != p0) begin
            errors++; $display("FAIL mid_pop_in_reset: got %0d pops required 0", pops - p0);
        end
        fifo_q.delete();
        drive_fifo();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hF0 + 32'(i));
        drive_fifo();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 128'h000000F3_000000F2_000000F1_000000F0) begin
            errors++; $display("FAIL mid_new_burst: valid=%b data=%h", rd_valid, rd_data);
        end
        tick();
        checks++;
        if (burst_cnt !== 16'd1) begin
            errors++; $display("FAIL mid_cnt: got %0d required 1", burst_cnt);
        end
    endtask

    task automatic test_streaming();
        int               n;
        int               p0;
        int               c0;
        logic [NB*DW-1:0] exp_data;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        rd_ready = 1'b1;
        hs_data.delete();
        hs_cycle.delete();
        for (int i = 0; i < 64; i++) fifo_q.push_back(32'h50000000 + 32'(i));
        drive_fifo();
        p0 = pops;
        c0 = cycle;
        n  = 0;
        while (hs_data.size() < 16 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (hs_data.size() != 16) begin
            errors++; $display("FAIL stream_count: got %0d bursts required 16", hs_data.size());
        end
        checks++;
        if (hs_cycle.size() > 0 && hs_cycle[0] - c0 != 4) begin
            errors++; $display("FAIL stream_first_lat: got %0d required 4", hs_cycle[0] - c0);
        end
        for (int b = 0; b < hs_data.size(); b++) begin
            for (int k = 0; k < NB; k++) exp_data[k*DW +: DW] = 32'h50000000 + 32'(b * NB + k);
            checks++;
            if (hs_data[b] !== exp_data) begin
                errors++; $display("FAIL stream_data[%0d]: got %h required %h", b, hs_data[b], exp_data);
            end
            if (b > 0) begin
                checks++;
                if (hs_cycle[b] - hs_cycle[b-1] != 5) begin
                    errors++;
                    $display("FAIL stream_period[%0d]: got %0d required 5", b,
                             hs_cycle[b] - hs_cycle[b-1]);
                end
            end
        end
        checks++;
        if (burst_cnt !== 16'd16) begin
            errors++; $display("FAIL stream_burst_cnt: got %0d required 16", burst_cnt);
        end
        checks++;
        if (pops - p0 != 64) begin
            errors++; $display("FAIL stream_pops: got %0d required 64", pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_gapped();
        test_mid_reset();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
